lfsr_rand_arbiter: RTL and testbench

//  Shares one 8-bit Fibonacci LFSR between N_REQ requesters (game logic, spawn timers, etc.).

---
 rtl/lfsr_rand_arbiter.sv | 149 ++++++++++++++
 tb/tb_lfsr_rand_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR; each grant steps it and rejection-samples into [0,RANGE-1].
// Optional build macro LFSR_RESEED_EN adds reseed_valid/reseed_data for loading the LFSR while idle.
module lfsr_rand_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter logic [7:0]  SEED     = 8'b10010011,
    parameter int unsigned RANGE    = 10,
    parameter int unsigned STEPS    = 8,
    parameter bit          FREE_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [7:0]       rand_out,
    output logic             busy
`ifdef LFSR_RESEED_EN
    ,
    input  logic             reseed_valid,
    input  logic [7:0]       reseed_data
`endif
);
    localparam int unsigned GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]  MASK     = 8'((1 << $clog2(RANGE)) - 1);
    localparam logic [7:0]  RANGE_V  = 8'(RANGE);
    localparam logic [3:0]  CNT_INIT = 4'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_CHECK, S_GRANT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [7:0]       rand_q, rand_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       sample;
    logic             reseed_now;
    logic [7:0]       reseed_val;

`ifdef LFSR_RESEED_EN
    assign reseed_now = reseed_valid;
    assign reseed_val = (reseed_data == 8'd0) ? SEED : reseed_data;
`else
    assign reseed_now = 1'b0;
    assign reseed_val = SEED;
`endif

    // An all-zero register would lock up the shifter, so it reloads SEED instead.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        if (v == 8'd0) begin
            return SEED;
        end
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Scan from farthest to nearest so the first requester after 'last' wins.
    function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [GW-1:0] last);
        logic [GW-1:0] p;
        logic [31:0]   idx;
        p = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (32'(last) + 32'(i)) % N_REQ;
            if (r[idx[GW-1:0]]) begin
                p = idx[GW-1:0];
            end
        end
        return p;
    endfunction

    assign sample = lfsr_q & MASK;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rand_d       = rand_q;
        ack_d        = '0;
        case (state_q)
            S_IDLE: begin
                if (reseed_now) begin
                    lfsr_d = reseed_val;
                end else begin
                    if (FREE_RUN) begin
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                    if (|req) begin
                        grant_d = rr_pick(req, last_grant_q);
                        cnt_d   = CNT_INIT;
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                if (!req[grant_q]) begin
                    state_d = S_IDLE;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q == 4'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_CHECK: begin
                // A withdrawn request aborts even when the sample would have been accepted.
                if (!req[grant_q]) begin
                    state_d = S_IDLE;
                end else if (sample < RANGE_V) begin
                    rand_d         = sample;
                    last_grant_d   = grant_q;
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_GRANT;
                end else begin
                    cnt_d   = '0;
                    state_d = S_STEP;
                end
            end
            S_GRANT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
            rand_q       <= '0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rand_q       <= rand_d;
            ack_q        <= ack_d;
        end
    end

    assign ack      = ack_q;
    assign rand_out = rand_q;
    assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter: directed vector table, multi-cycle corner sequences, and a randomized run
// against a transaction-level reference model (default parameters).
module tb_lfsr_rand_arbiter;
    localparam int         C_RANGE = 10;
    localparam int         C_STEPS = 8;
    localparam bit         C_FREE  = 1'b1;
    localparam logic [7:0] C_SEED  = 8'h93;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] ack_a, ack_b, ack_c;
    logic [7:0] rand_a, rand_b, rand_c;
    logic       busy_a, busy_b, busy_c;
`ifdef LFSR_RESEED_EN
    logic       rs_v;
    logic [7:0] rs_d;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(.N_REQ(4), .SEED(C_SEED), .RANGE(10), .STEPS(8), .FREE_RUN(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .ack(ack_a), .rand_out(rand_a), .busy(busy_a)
`ifdef LFSR_RESEED_EN
        , .reseed_valid(1'b0), .reseed_data(8'h00)
`endif
    );

    lfsr_rand_arbiter #(.N_REQ(4), .SEED(C_SEED), .RANGE(5), .STEPS(1), .FREE_RUN(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .ack(ack_b), .rand_out(rand_b), .busy(busy_b)
`ifdef LFSR_RESEED_EN
        , .reseed_valid(rs_v), .reseed_data(rs_d)
`endif
    );

    lfsr_rand_arbiter dut_c (
        .clk(clk), .rst(rst_c), .req(req_c), .ack(ack_c), .rand_out(rand_c), .busy(busy_c)
`ifdef LFSR_RESEED_EN
        , .reseed_valid(1'b0), .reseed_data(8'h00)
`endif
    );

    typedef struct {
        int         dut;
        bit         do_rst;
        logic [3:0] req;
        logic [3:0] exp_ack;
        logic [7:0] exp_rand;
        int         exp_lat;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic drive_req(input int w, input logic [3:0] r);
        if (w == 0) req_a = r;
        else        req_b = r;
    endtask

    function automatic logic [3:0] cur_ack(input int w);
        return (w == 0) ? ack_a : ack_b;
    endfunction

    function automatic logic [7:0] cur_rand(input int w);
        return (w == 0) ? rand_a : rand_b;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    // Called at a negedge; returns edges seen until ack observed (acceptance edge counts as 1).
    task automatic wait_ack(input int w, output int lat, output logic [3:0] a);
        lat = 0;
        a   = '0;
        while (lat < 600) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            a = cur_ack(w);
            if (a != 4'd0) break;
        end
    endtask

    task automatic pulse_rst(input int w);
        if (w == 0) rst_a = 1'b1;
        else        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (w == 0) rst_a = 1'b0;
        else        rst_b = 1'b0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    int         m_phase;  // 0 idle, 1 transaction running, 2 ack cycle
    logic [7:0] m_lfsr;
    int         m_last, m_g, m_d, m_total;
    logic [7:0] m_vals[$];
    logic [3:0] e_ack;
    logic [7:0] e_rand;
    logic       e_busy;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        if (v == 8'd0) return C_SEED;
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int range_mask();
        int m = 1;
        while (m < C_RANGE) m = m * 2;
        return m - 1;
    endfunction

    // Steps completed d edges after acceptance: STEPS straight, then one per check/step pair.
    function automatic int steps_done(input int d);
        return (d <= C_STEPS) ? d : C_STEPS + (d - C_STEPS) / 2;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        e_ack = '0;
        if (rs) begin
            m_phase = 0;
            m_lfsr  = C_SEED;
            m_last  = 3;
            e_rand  = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (C_FREE) m_lfsr = lfsr_next(m_lfsr);
                    if (r != 4'd0) begin
                        m_g = -1;
                        for (int i = 1; i <= 4; i++)
                            if (m_g < 0 && r[(m_last + i) % 4]) m_g = (m_last + i) % 4;
                        m_vals.delete();
                        m_vals.push_back(m_lfsr);
                        for (int i = 0; i < C_STEPS; i++) m_vals.push_back(lfsr_next(m_vals[$]));
                        while (int'(m_vals[$] & 8'(range_mask())) >= C_RANGE)
                            m_vals.push_back(lfsr_next(m_vals[$]));
                        m_total = C_STEPS + 1 + 2 * (m_vals.size() - 1 - C_STEPS);
                        m_d     = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_d++;
                    if (!r[m_g]) begin
                        m_lfsr  = m_vals[steps_done(m_d - 1)];
                        m_phase = 0;
                    end else if (m_d == m_total) begin
                        m_lfsr     = m_vals[$];
                        e_rand     = m_vals[$] & 8'(range_mask());
                        m_last     = m_g;
                        e_ack[m_g] = 1'b1;
                        m_phase    = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        e_busy = (m_phase != 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [3:0] a;
        logic [3:0] exp_oh;
        int         seen;

        vecs[0] = '{0, 1'b1, 4'b0001, 4'b0001, 8'd2, 9};
        vecs[1] = '{0, 1'b0, 4'b0001, 4'b0001, 8'd5, 11};
        vecs[2] = '{0, 1'b0, 4'b0110, 4'b0010, 8'd5, 9};
        vecs[3] = '{1, 1'b1, 4'b0001, 4'b0001, 8'd3, 6};
        vecs[4] = '{1, 1'b1, 4'b0010, 4'b0010, 8'd3, 6};
        vecs[5] = '{1, 1'b1, 4'b1100, 4'b0100, 8'd3, 6};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
`ifdef LFSR_RESEED_EN
        rs_v = 1'b0; rs_d = 8'h00;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        check("reset_a", 32'({ack_a, rand_a, busy_a}), 32'd0);
        check("reset_b", 32'({ack_b, rand_b, busy_b}), 32'd0);
        check("reset_c", 32'({ack_c, rand_c, busy_c}), 32'd0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_rst) pulse_rst(vecs[i].dut);
            drive_req(vecs[i].dut, vecs[i].req);
            wait_ack(vecs[i].dut, lat, a);
            drive_req(vecs[i].dut, 4'd0);
            $display("txn vec%0d dut%0d req=%b ack=%b rand=%0d lat=%0d", i, vecs[i].dut, vecs[i].req, a,
                     cur_rand(vecs[i].dut), lat - 1);
            check($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_rand", i), 32'(cur_rand(vecs[i].dut)), 32'(vecs[i].exp_rand));
            check($sformatf("vec%0d_lat", i), 32'(lat - 1), 32'(vecs[i].exp_lat));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_after", i), 32'({cur_ack(vecs[i].dut), cur_busy(vecs[i].dut)}), 32'd0);
        end

        // Round robin with all requesters, each re-raised one cycle after its ack
        pulse_rst(0);
        req_a = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack(0, lat, a);
            exp_oh = 4'b0001 << (n % 4);
            $display("txn rr%0d ack=%b rand=%0d", n, a, rand_a);
            check($sformatf("rr%0d_ack", n), 32'(a), 32'(exp_oh));
            req_a = req_a & ~a;
            @(posedge clk);
            @(negedge clk);
            req_a = req_a | a;
        end
        req_a = '0;
        repeat (12) @(negedge clk);

        // Abort three cycles into STEP, then a normal grant
        pulse_rst(0);
        req_a = 4'b0100;
        repeat (4) @(posedge clk);
        @(negedge clk);
        req_a = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy_a), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (ack_a != 4'd0) seen++;
            @(negedge clk);
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        req_a = 4'b1001;
        wait_ack(0, lat, a);
        req_a = '0;
        $display("txn abort_next ack=%b rand=%0d lat=%0d", a, rand_a, lat - 1);
        check("abort_next_ack", 32'(a), 32'b0001);
        check("abort_next_rand", 32'(rand_a), 32'd0);
        check("abort_next_lat", 32'(lat - 1), 32'd9);
        @(posedge clk);
        @(negedge clk);

        // Reset while in CHECK
        pulse_rst(0);
        req_a = 4'b0001;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("chk_busy_before_rst", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_check", 32'({ack_a, rand_a, busy_a}), 32'd0);
        rst_a = 1'b0;
        req_a = 4'b1111;
        wait_ack(0, lat, a);
        req_a = '0;
        $display("txn post_rst ack=%b rand=%0d lat=%0d", a, rand_a, lat - 1);
        check("post_rst_ack", 32'(a), 32'b0001);
        check("post_rst_rand", 32'(rand_a), 32'd2);
        check("post_rst_lat", 32'(lat - 1), 32'd9);
        @(posedge clk);
        @(negedge clk);

`ifdef LFSR_RESEED_EN
        pulse_rst(1);
        rs_v = 1'b1; rs_d = 8'h01; req_b = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        rs_v = 1'b0;
        check("reseed_priority", 32'(busy_b), 32'd0);
        wait_ack(1, lat, a);
        req_b = '0;
        $display("txn reseed01 ack=%b rand=%0d lat=%0d", a, rand_b, lat - 1);
        check("reseed01_ack", 32'(a), 32'b0010);
        check("reseed01_rand", 32'(rand_b), 32'd2);
        check("reseed01_lat", 32'(lat - 1), 32'd2);
        @(posedge clk);
        @(negedge clk);
        rs_v = 1'b1; rs_d = 8'h00; req_b = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        rs_v = 1'b0;
        wait_ack(1, lat, a);
        req_b = '0;
        $display("txn reseed00 ack=%b rand=%0d lat=%0d", a, rand_b, lat - 1);
        check("reseed00_rand", 32'(rand_b), 32'd3);
        check("reseed00_lat", 32'(lat - 1), 32'd6);
        @(posedge clk);
        @(negedge clk);
`endif

        // Randomized run on the default-parameter instance
        rst_c = 1'b1;
        req_c = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            model_step(req_c, rst_c);
            @(negedge clk);
            check($sformatf("rand_cyc%0d", cyc), 32'({ack_c, rand_c, busy_c}), 32'({e_ack, e_rand, e_busy}));
            if (e_ack != 4'd0) $display("txn rand cyc%0d ack=%b rand=%0d", cyc, ack_c, rand_c);
            rst_c = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 4; i++) begin
                if (req_c[i]) begin
                    if (e_ack[i] || $urandom_range(0, 79) == 0) req_c[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_c[i] = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
